// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs R/I/S/B fields into 32-bit words, buffers them in a FIFO
// and writes them to consecutive imem word addresses. Optional macro: INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_fmt,
    input  logic [6:0]                   in_opcode,
    input  logic [2:0]                   in_funct3,
    input  logic [6:0]                   in_funct7,
    input  logic [4:0]                   in_rs1,
    input  logic [4:0]                   in_rs2,
    input  logic [4:0]                   in_rd,
    input  logic [31:0]                  in_imm,
    input  logic                         addr_clr,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_ready,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_S = 2'd2;

    logic [31:0]       fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       last_q;
    logic              err_q;

    logic [31:0] word;
    logic        imm_bad;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        word = '0;
        case (in_fmt)
            FMT_R:   word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I:   word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S:   word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            default: word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    always_comb begin
        imm_bad = 1'b0;
        case (in_fmt)
            FMT_R:   imm_bad = 1'b0;
            FMT_I,
            FMT_S:   imm_bad = ($signed(in_imm) < -32'sd2048) || ($signed(in_imm) > 32'sd2047);
            default: imm_bad = ($signed(in_imm) < -32'sd4096) || ($signed(in_imm) > 32'sd4094)
                               || in_imm[0];
        endcase
    end
`else
    // Upper immediate bits only matter to the range check; without it they are truncated.
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[31:13];
    assign imm_bad = 1'b0;
`endif

    // Full blocks input even when a pop happens in the same cycle.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign mem_we    = (count_q != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !imm_bad;
    assign pop       = mem_we && mem_ready;
    assign mem_addr  = addr_q;
    assign mem_wdata = mem_we ? fifo_q[rd_ptr_q] : last_q;
    assign pending   = count_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE;
            last_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                last_q   <= fifo_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            // A retiring write has already used the old address; clear takes priority.
            if (addr_clr) begin
                addr_q <= BASE;
            end else if (pop) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (accept && imm_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= word;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, backpressure, address wrap/clear, reset.
module tb_instr_encoder;

    typedef struct {
        logic [1:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] word;
    } vec_t;

    localparam int NV = 11;

    logic        clk = 1'b0;
    logic        rst, b_rst;
    logic        in_valid, b_in_valid;
    logic        in_ready, b_in_ready;
    logic [1:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_imm;
    logic        addr_clr, b_addr_clr;
    logic        mem_we, b_mem_we;
    logic [9:0]  mem_addr;
    logic [1:0]  b_mem_addr;
    logic [31:0] mem_wdata, b_mem_wdata;
    logic        mem_ready, b_mem_ready;
    logic [2:0]  pending, b_pending;
    logic        err, b_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    vec_t vec [NV];
    logic [31:0] exp_q [$];
    logic [9:0]  exp_addr = 10'd0;
    logic [1:0]  b_exp [5];

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .addr_clr(addr_clr), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .pending(pending), .err(err)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(1)) dut2 (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .addr_clr(b_addr_clr), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_ready(b_mem_ready), .pending(b_pending), .err(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_fmt = v.fmt; in_opcode = v.op; in_funct3 = v.f3; in_funct7 = v.f7;
        in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd; in_imm = v.imm;
    endtask

    // Scoreboard for the main instance: every retiring write must match the next expected word.
    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", mem_wdata, 32'hxxxxxxxx);
            end else begin
                chk("write_data", mem_wdata, exp_q.pop_front());
                chk("write_addr", {22'd0, mem_addr}, {22'd0, exp_addr});
                exp_addr = exp_addr + 10'd1;
            end
        end
    end

    initial begin
        vec[0]  = '{2'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0,  5'd1,  32'd5,        32'h00500093};
        vec[1]  = '{2'd0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2,  5'd3,  32'h12345678, 32'h002081B3};
        vec[2]  = '{2'd2, 7'h23, 3'd2, 7'h55, 5'd1, 5'd2,  5'd9,  32'd8,        32'h0020A423};
        vec[3]  = '{2'd3, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2,  5'd0,  32'hFFFFFFFC, 32'hFE208EE3};
        vec[4]  = '{2'd0, 7'h33, 3'd0, 7'h20, 5'd6, 5'd7,  5'd5,  32'h0,        32'h407302B3};
        vec[5]  = '{2'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0,  5'd1,  32'hFFFFFFFF, 32'hFFF08093};
        vec[6]  = '{2'd1, 7'h03, 3'd2, 7'h7F, 5'd2, 5'd31, 5'd10, 32'hFFFFF800, 32'h80012503};
        vec[7]  = '{2'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd31, 5'd7,  32'hFFFFFFFF, 32'hFFF02FA3};
        vec[8]  = '{2'd3, 7'h63, 3'd1, 7'h00, 5'd3, 5'd4,  5'd0,  32'h00000FFE, 32'h7E419FE3};
        vec[9]  = '{2'd3, 7'h63, 3'd4, 7'h00, 5'd0, 5'd0,  5'd0,  32'hFFFFF000, 32'h80004063};
        vec[10] = '{2'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0,  5'd0,  32'h000007FF, 32'h7FF00013};
        b_exp[0] = 2'd1; b_exp[1] = 2'd2; b_exp[2] = 2'd3; b_exp[3] = 2'd0; b_exp[4] = 2'd1;

        rst = 1'b1; b_rst = 1'b1;
        in_valid = 1'b0; b_in_valid = 1'b0;
        addr_clr = 1'b0; b_addr_clr = 1'b0;
        mem_ready = 1'b1; b_mem_ready = 1'b1;
        drive(vec[0]);
        tick(); tick();
        rst = 1'b0; b_rst = 1'b0;
        chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset_pending", {29'd0, pending}, 32'd0);
        chk("reset_addr", {22'd0, mem_addr}, 32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Encoding table, one beat at a time with memory always ready
        for (int i = 0; i < NV; i++) begin
            drive(vec[i]);
            in_valid = 1'b1;
            tick();
            exp_q.push_back(vec[i].word);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_latency_we", i), {31'd0, mem_we}, 32'd1);
            chk($sformatf("vec%0d_word", i), mem_wdata, vec[i].word);
            tick();
        end
        chk("empty_we", {31'd0, mem_we}, 32'd0);
        chk("empty_holds_last", mem_wdata, vec[NV-1].word);
        chk("addr_after_table", {22'd0, mem_addr}, 32'd11);

        // Backpressure: fill, stall, release
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(vec[k]);
            in_valid = 1'b1;
            tick();
            exp_q.push_back(vec[k].word);
        end
        chk("full_pending", {29'd0, pending}, 32'd4);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        drive(vec[4]);
        tick();
        chk("stall_pending", {29'd0, pending}, 32'd4);
        chk("stall_addr", {22'd0, mem_addr}, 32'd11);
        chk("stall_wdata", mem_wdata, vec[0].word);
        mem_ready = 1'b1;
        tick();
        chk("no_passthrough_pending", {29'd0, pending}, 32'd3);
        chk("ready_after_pop", {31'd0, in_ready}, 32'd1);
        tick();
        exp_q.push_back(vec[4].word);
        in_valid = 1'b0;
        chk("push_pop_pending", {29'd0, pending}, 32'd3);
        for (int i = 0; i < 20 && mem_we; i++) tick();
        chk("drain_done", {31'd0, mem_we}, 32'd0);
        chk("addr_after_drain", {22'd0, mem_addr}, 32'd16);

        // Out-of-range I immediate (2048)
        in_fmt = 2'd1; in_opcode = 7'h13; in_funct3 = 3'd0; in_rd = 5'd1; in_rs1 = 5'd0;
        in_imm = 32'd2048;
        in_valid = 1'b1;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        tick();
        in_valid = 1'b0;
        chk("range_no_push", {31'd0, mem_we}, 32'd0);
        chk("range_err", {31'd0, err}, 32'd1);
        in_fmt = 2'd3; in_imm = 32'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("odd_b_no_push", {29'd0, pending}, 32'd0);
        drive(vec[0]);
        in_valid = 1'b1;
        tick();
        exp_q.push_back(vec[0].word);
        in_valid = 1'b0;
        chk("range_then_push", {31'd0, mem_we}, 32'd1);
        chk("err_sticky", {31'd0, err}, 32'd1);
        tick();
`else
        tick();
        exp_q.push_back(32'h80000093);
        in_valid = 1'b0;
        chk("trunc_we", {31'd0, mem_we}, 32'd1);
        chk("trunc_word", mem_wdata, 32'h80000093);
        chk("err_tied_low", {31'd0, err}, 32'd0);
        tick();
`endif
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        // Second instance: ADDR_W=2, BASE_ADDR=1 -> wraps to 0, not to base
        for (int k = 0; k < 5; k++) begin
            drive(vec[k]);
            b_in_valid = 1'b1;
            tick();
            b_in_valid = 1'b0;
            chk($sformatf("wrap_addr%0d", k), {30'd0, b_mem_addr}, {30'd0, b_exp[k]});
            chk($sformatf("wrap_word%0d", k), b_mem_wdata, vec[k].word);
            tick();
        end
        chk("wrap_next_addr", {30'd0, b_mem_addr}, 32'd2);
        drive(vec[5]);
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        b_addr_clr = 1'b1;
        chk("clr_retire_uses_old", {30'd0, b_mem_addr}, 32'd2);
        tick();
        b_addr_clr = 1'b0;
        chk("clr_wins_increment", {30'd0, b_mem_addr}, 32'd1);
        chk("clr_retired", {31'd0, b_mem_we}, 32'd0);

        // Reset mid-operation discards buffered words
        b_mem_ready = 1'b0;
        b_in_valid = 1'b1;
        tick(); tick();
        b_in_valid = 1'b0;
        chk("pre_reset_pending", {29'd0, b_pending}, 32'd2);
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        b_mem_ready = 1'b1;
        tick();
        chk("midreset_pending", {29'd0, b_pending}, 32'd0);
        chk("midreset_we", {31'd0, b_mem_we}, 32'd0);
        chk("midreset_addr", {30'd0, b_mem_addr}, 32'd1);
        chk("midreset_wdata", b_mem_wdata, 32'd0);
        chk("midreset_in_ready", {31'd0, b_in_ready}, 32'd1);
        chk("b_err_clear", {31'd0, b_err}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
